// File: rtl/ufo_pkg.sv
// ufo_pkg: shared mystery-ship game types and constants.
//   ufo_hit_state_t  - hit manager state (ARMED / EXPLODING / COOLDOWN)
//   SCORE_*          - point values awarded for a ship kill
//   SCORE_300_SHOT   - shot-counter value that earns the top award
//   shot_score()     - maps the 4-bit shot counter to a point value
package ufo_pkg;

    typedef enum logic [1:0] {
        ARMED     = 2'd0,
        EXPLODING = 2'd1,
        COOLDOWN  = 2'd2
    } ufo_hit_state_t;

    localparam logic [8:0] SCORE_50  = 9'd50;
    localparam logic [8:0] SCORE_100 = 9'd100;
    localparam logic [8:0] SCORE_150 = 9'd150;
    localparam logic [8:0] SCORE_300 = 9'd300;

    localparam logic [3:0] SCORE_300_SHOT = 4'd14;

    // Shot 14 is the jackpot; otherwise the low two bits cycle 50/100/150/100.
    function automatic logic [8:0] shot_score(input logic [3:0] shots);
        logic [8:0] pts;
        if (shots == SCORE_300_SHOT) begin
            pts = SCORE_300;
        end else begin
            case (shots[1:0])
                2'd0:    pts = SCORE_50;
                2'd1:    pts = SCORE_100;
                2'd2:    pts = SCORE_150;
                default: pts = SCORE_100;
            endcase
        end
        return pts;
    endfunction

endpackage

// File: rtl/ufo_hit_manager_if.sv
// ufo_hit_manager_if: signals between the VGA drawers / movement / score /
// display logic and the ship hit manager.
//   master - drives draw requests, frame/shot pulses and ship X; sees results
//   slave  - the hit manager: consumes requests, produces collision, kill,
//            score and explosion overlay
interface ufo_hit_manager_if;
    logic               startOfFrame;
    logic               shipDrawingRequest;
    logic               missileDrawingRequest;
    logic               shotFired;
    logic signed [10:0] shipTopLeftX;

    logic               collision;
    logic               missileKill;
    logic               scoreValid;
    logic [8:0]         scoreValue;
    logic               explodeEnable;
    logic signed [10:0] explodeX;

    modport master (
        output startOfFrame, shipDrawingRequest, missileDrawingRequest,
               shotFired, shipTopLeftX,
        input  collision, missileKill, scoreValid, scoreValue,
               explodeEnable, explodeX
    );

    modport slave (
        input  startOfFrame, shipDrawingRequest, missileDrawingRequest,
               shotFired, shipTopLeftX,
        output collision, missileKill, scoreValid, scoreValue,
               explodeEnable, explodeX
    );
endinterface

// File: rtl/ufo_hit_manager_frame_timer.sv
// frame_timer: counts start-of-frame pulses while enabled.
//   clk, resetN     - clock, async active-low reset
//   clear           - hold the count at zero
//   enable          - count start_of_frame pulses
//   start_of_frame  - one-clk frame pulse
//   terminal        - last count value of the period
//   done            - combinational, high on the start_of_frame that arrives
//                     while the count equals terminal; the count wraps to 0
module frame_timer #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         clear,
    input  logic         enable,
    input  logic         start_of_frame,
    input  logic [W-1:0] terminal,
    output logic         done
);
    logic [W-1:0] cnt;

    assign done = enable && start_of_frame && (cnt == terminal);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            cnt <= '0;
        else if (clear || done)
            cnt <= '0;
        else if (enable && start_of_frame)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/ufo_hit_manager.sv
// ufo_hit_manager: turns the first ship/missile pixel overlap into a one-clk
// collision / missile-kill / score pulse, then runs a frame-timed explosion
// overlay followed by a cooldown during which overlaps are ignored.
//   clk, resetN - clock, async active-low reset
//   bus (slave) - draw requests, frame/shot pulses, ship X in; collision,
//                 missileKill, scoreValid/scoreValue, explodeEnable/explodeX out
module ufo_hit_manager
    import ufo_pkg::*;
#(
    parameter int EXPLODE_FRAMES  = 30,
    parameter int COOLDOWN_FRAMES = 60
) (
    input  logic             clk,
    input  logic             resetN,
    ufo_hit_manager_if.slave bus
);
    localparam int MAXF = (EXPLODE_FRAMES > COOLDOWN_FRAMES) ? EXPLODE_FRAMES : COOLDOWN_FRAMES;
    localparam int FW   = (MAXF > 2) ? $clog2(MAXF) : 1;

    ufo_hit_state_t     state, state_nxt;
    logic [3:0]         shot_cnt;
    logic               pulse, pulse_nxt;
    logic [8:0]         score_q, score_nxt;
    logic               en_q, en_nxt;
    logic signed [10:0] x_q, x_nxt;

    logic               hit;
    logic               timer_clear, timer_en, timer_done;
    logic [FW-1:0]      timer_term;

    assign hit        = bus.shipDrawingRequest && bus.missileDrawingRequest;
    assign timer_en   = (state == EXPLODING) || (state == COOLDOWN);
    assign timer_term = (state == EXPLODING) ? FW'(EXPLODE_FRAMES - 1)
                                             : FW'(COOLDOWN_FRAMES - 1);

    frame_timer #(.W(FW)) u_timer (
        .clk            (clk),
        .resetN         (resetN),
        .clear          (timer_clear),
        .enable         (timer_en),
        .start_of_frame (bus.startOfFrame),
        .terminal       (timer_term),
        .done           (timer_done)
    );

    always_comb begin
        state_nxt   = state;
        pulse_nxt   = 1'b0;
        score_nxt   = score_q;
        en_nxt      = en_q;
        x_nxt       = x_q;
        timer_clear = 1'b0;
        case (state)
            ARMED: begin
                // Timer held at zero so a coincident startOfFrame is not counted.
                timer_clear = 1'b1;
                if (hit) begin
                    pulse_nxt = 1'b1;
                    score_nxt = shot_score(shot_cnt);
                    x_nxt     = bus.shipTopLeftX;
                    en_nxt    = 1'b1;
                    state_nxt = EXPLODING;
                end
            end
            EXPLODING: begin
                if (timer_done) begin
                    en_nxt    = 1'b0;
                    state_nxt = COOLDOWN;
                end
            end
            COOLDOWN: begin
                if (timer_done)
                    state_nxt = ARMED;
            end
            default: state_nxt = ARMED;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= ARMED;
            shot_cnt <= '0;
            pulse    <= 1'b0;
            score_q  <= '0;
            en_q     <= 1'b0;
            x_q      <= '0;
        end else begin
            state    <= state_nxt;
            shot_cnt <= shot_cnt + {3'b000, bus.shotFired};
            pulse    <= pulse_nxt;
            score_q  <= score_nxt;
            en_q     <= en_nxt;
            x_q      <= x_nxt;
        end
    end

    assign bus.collision     = pulse;
    assign bus.missileKill   = pulse;
    assign bus.scoreValid    = pulse;
    assign bus.scoreValue    = score_q;
    assign bus.explodeEnable = en_q;
    assign bus.explodeX      = x_q;
endmodule

// File: tb/tb_ufo_hit_manager.sv
// tb_ufo_hit_manager: vector table, hand-written corner sequences and a
// randomized run against a frames-remaining reference model.
module tb_ufo_hit_manager;
    localparam int EXP_F  = 30;
    localparam int COOL_F = 60;

    logic clk = 1'b0;
    logic resetN;
    always #5 clk = ~clk;

    ufo_hit_manager_if bus ();

    ufo_hit_manager #(.EXPLODE_FRAMES(EXP_F), .COOLDOWN_FRAMES(COOL_F)) dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: frames remaining in each timed phase.
    int m_shots, m_expl, m_cool, m_score, m_x;
    bit m_pulse;

    typedef struct {
        bit sdr, mdr, sof, shot;
        int x;
        bit ecol;
        int escore;
        bit een;
        int ex;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int ref_score(input int s);
        int t[4] = '{50, 100, 150, 100};
        if (s == 14) return 300;
        return t[s % 4];
    endfunction

    task automatic model_reset();
        m_shots = 0; m_expl = 0; m_cool = 0; m_score = 0; m_x = 0; m_pulse = 0;
    endtask

    task automatic model_edge(input bit sdr, input bit mdr, input bit sof, input bit shot, input int x);
        m_pulse = 0;
        if (m_expl == 0 && m_cool == 0) begin
            if (sdr && mdr) begin
                m_pulse = 1;
                m_score = ref_score(m_shots);
                m_x     = x;
                m_expl  = EXP_F;
                m_cool  = COOL_F;
            end
        end else if (sof) begin
            if (m_expl > 0) m_expl--;
            else            m_cool--;
        end
        m_shots = (m_shots + (shot ? 1 : 0)) % 16;
    endtask

    task automatic compare_model();
        check("collision",     int'(bus.collision),     int'(m_pulse));
        check("missileKill",   int'(bus.missileKill),   int'(m_pulse));
        check("scoreValid",    int'(bus.scoreValid),    int'(m_pulse));
        check("scoreValue",    int'(bus.scoreValue),    m_score);
        check("explodeEnable", int'(bus.explodeEnable), (m_expl > 0) ? 1 : 0);
        check("explodeX",      int'(bus.explodeX),      m_x);
    endtask

    task automatic drive(input bit sdr, input bit mdr, input bit sof, input bit shot, input int x);
        logic [31:0] xv;
        xv = x;
        bus.shipDrawingRequest    = sdr;
        bus.missileDrawingRequest = mdr;
        bus.startOfFrame          = sof;
        bus.shotFired             = shot;
        bus.shipTopLeftX          = xv[10:0];
    endtask

    task automatic step(input bit sdr, input bit mdr, input bit sof, input bit shot, input int x);
        @(negedge clk);
        drive(sdr, mdr, sof, shot, x);
        @(posedge clk);
        model_edge(sdr, mdr, sof, shot, x);
        #1;
        compare_model();
    endtask

    // Reset asserted between edges so the zeroing must be asynchronous.
    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0);
        #2 resetN = 1'b0;
        #1;
        check("rst_collision", int'(bus.collision),     0);
        check("rst_missile",   int'(bus.missileKill),   0);
        check("rst_valid",     int'(bus.scoreValid),    0);
        check("rst_value",     int'(bus.scoreValue),    0);
        check("rst_enable",    int'(bus.explodeEnable), 0);
        check("rst_x",         int'(bus.explodeX),      0);
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        int ncol, nval;
        resetN = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        #12;
        resetN = 1'b1;

        // Vector table: basic hit at X=200 with shot counter 0.
        vecs[0] = '{0, 0, 0, 0, 200, 0, 0,  0, 0};
        vecs[1] = '{1, 1, 0, 0, 200, 1, 50, 1, 200};
        vecs[2] = '{0, 0, 0, 0, 300, 0, 50, 1, 200};
        vecs[3] = '{1, 1, 0, 0, 400, 0, 50, 1, 200};
        vecs[4] = '{1, 0, 1, 1, 500, 0, 50, 1, 200};
        vecs[5] = '{0, 1, 0, 0, 600, 0, 50, 1, 200};
        do_reset();
        foreach (vecs[i]) begin
            step(vecs[i].sdr, vecs[i].mdr, vecs[i].sof, vecs[i].shot, vecs[i].x);
            check("tbl_collision", int'(bus.collision),     int'(vecs[i].ecol));
            check("tbl_score",     int'(bus.scoreValue),    vecs[i].escore);
            check("tbl_enable",    int'(bus.explodeEnable), int'(vecs[i].een));
            check("tbl_x",         int'(bus.explodeX),      vecs[i].ex);
        end

        // Overlap held for 20 pixels: one pulse only.
        do_reset();
        ncol = 0; nval = 0;
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 0, 0, 123);
            ncol += int'(bus.collision);
            nval += int'(bus.scoreValid);
        end
        step(0, 0, 0, 0, 0);
        check("hold20_collisions", ncol, 1);
        check("hold20_valids",     nval, 1);

        // 14 shots, hit with a coincident shot -> 300; counter then reads 15.
        do_reset();
        for (int i = 0; i < 14; i++) step(0, 0, 0, 1, 0);
        step(1, 1, 0, 1, 50);
        check("shot14_score", int'(bus.scoreValue), 300);
        check("shot14_col",   int'(bus.collision),  1);
        for (int i = 1; i <= EXP_F; i++) begin
            step(0, 0, 1, 0, 0);
            check("explode_len", int'(bus.explodeEnable), (i < EXP_F) ? 1 : 0);
        end
        ncol = 0;
        for (int i = 1; i <= COOL_F; i++) begin
            step(1, 1, 0, 0, 0);
            ncol += int'(bus.collision);
            step(0, 0, 1, 0, 0);
        end
        check("cooldown_ignored", ncol, 0);
        step(1, 1, 0, 0, -77);
        check("rearm_col",   int'(bus.collision),  1);
        check("rearm_score", int'(bus.scoreValue), 100);
        check("rearm_x",     int'(bus.explodeX),   -77);

        // Hit coincident with startOfFrame: that frame is not counted.
        do_reset();
        step(1, 1, 1, 0, -5);
        check("sof_hit_col", int'(bus.collision), 1);
        check("sof_hit_x",   int'(bus.explodeX),  -5);
        for (int i = 1; i <= EXP_F; i++) begin
            step(0, 0, 1, 0, 0);
            check("sof_hit_len", int'(bus.explodeEnable), (i < EXP_F) ? 1 : 0);
        end

        // Reset during explosion frame 10, then an immediate new hit.
        do_reset();
        step(0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 99);
        for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 0);
        check("mid_enable", int'(bus.explodeEnable), 1);
        do_reset();
        step(1, 1, 0, 0, 200);
        check("post_rst_col",   int'(bus.collision),  1);
        check("post_rst_score", int'(bus.scoreValue), 50);

        // Randomized run against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 2047)) - 1024);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ufo_hit_manager.md
Name: ufo_hit_manager

Overview:
- Consumer side of the mystery-ship movement block.
- Watches the ship and player-missile pixel draw requests and turns an overlap into a one-cycle collision pulse, which is returned to the movement block to re-park the ship off-screen.
- Also produces a missile-kill pulse, a score award and a frame-timed explosion overlay.
- Sits between the VGA object drawers and the movement/score/display logic.

Parameters:
- EXPLODE_FRAMES, 30: frames the explosion overlay stays active after a hit.
- COOLDOWN_FRAMES, 60: frames after the explosion during which overlaps are ignored.

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-clk pulse per frame.
- shipDrawingRequest  in  1  ship pixel active at the current pixel.
- missileDrawingRequest  in  1  player-missile pixel active at the current pixel.
- shotFired  in  1  one-clk pulse per player shot.
- shipTopLeftX  in  11 signed  current ship X from the movement block.
- collision  out  1  one-clk pulse to the movement block.
- missileKill  out  1  one-clk pulse to the missile block.
- scoreValid  out  1  one-clk pulse; scoreValue is valid when high.
- scoreValue  out  9  points awarded (50/100/150/300).
- explodeEnable  out  1  explosion overlay active.
- explodeX  out  11 signed  latched X position of the explosion.

Behaviour:
- Reset is asynchronous, active-low, on clk. During reset:
  - state = ARMED, shot counter = 0, frame counter = 0.
  - All outputs = 0, explodeX = 0.
- States: ARMED, EXPLODING, COOLDOWN.
- ARMED: a hit is shipDrawingRequest & missileDrawingRequest sampled on a clk edge. On the edge after a hit:
  - collision = missileKill = scoreValid = 1 for exactly one cycle.
  - explodeX <= shipTopLeftX, sampled at the hit edge.
  - scoreValue <= score(shot counter value at the hit edge).
  - explodeEnable <= 1; frame counter <= 0; state -> EXPLODING.
- Only the first overlapping pixel counts. Further overlap pixels in the same frame are ignored because state is no longer ARMED.
- EXPLODING:
  - Each startOfFrame increments the frame counter.
  - When the counter reaches EXPLODE_FRAMES-1 and startOfFrame occurs: explodeEnable <= 0, counter <= 0, state -> COOLDOWN.
  - Overlaps are ignored.
- COOLDOWN:
  - Same counting as EXPLODING, with terminal value COOLDOWN_FRAMES-1; on that startOfFrame, state -> ARMED.
  - Overlaps are ignored.
- Shot counter: 4-bit, increments on shotFired, wraps 15->0. Never cleared except by reset.
- Score table (index = shot counter):
  - counter == 14 -> 300.
  - Otherwise by counter[1:0]: 0->50, 1->100, 2->150, 3->100.
- Simultaneous events:
  - Hit and shotFired on the same edge: score uses the pre-increment counter value; the counter still increments.
  - Hit and startOfFrame on the same edge in ARMED: the hit is taken and the frame counter starts at 0 (that startOfFrame is not counted).
  - startOfFrame and a hit in EXPLODING/COOLDOWN: the hit is ignored, the frame is counted.
- scoreValue holds its last value between pulses; consumers qualify it with scoreValid.
- Reset mid-explosion or mid-cooldown: immediate return to reset values, with no pulse emitted.
- Width rules:
  - Frame counter is wide enough for max(EXPLODE_FRAMES, COOLDOWN_FRAMES); saturation is not needed.
  - explodeX is a straight signed copy; no clamping, so negative or off-screen X values are preserved.

Decomposition:
- Shared game package (ufo_pkg):
  - typedef enum for ufo_hit_state_t {ARMED, EXPLODING, COOLDOWN}.
  - Score constants SCORE_50, SCORE_100, SCORE_150, SCORE_300.
  - Index constant SCORE_300_SHOT = 14.
- One sub-module: frame_timer. It counts startOfFrame pulses and has inputs clear, enable, terminal count, and output done, asserted combinationally on the terminal-count startOfFrame. It is instantiated once and shared by both timed states.

Test Plan:
- Reset, then a single-pixel overlap at shipTopLeftX=200 with shot counter 0 -> next cycle: collision, missileKill, scoreValid each high for 1 clk; scoreValue=50; explodeX=200; explodeEnable=1.
- Overlap held for 20 consecutive pixels in one frame -> exactly one collision pulse and one scoreValid pulse.
- 14 shotFired pulses, then a hit -> scoreValue=300. With shotFired on the same edge as the hit, the counter reads 15 afterwards.
- After a hit, apply startOfFrame pulses -> explodeEnable falls on the 30th pulse. Overlaps during the next 60 frames give no pulses; an overlap after the 60th startOfFrame gives collision.
- Hit coincident with startOfFrame -> explodeEnable lasts 30 further startOfFrame pulses, not 29.
- resetN asserted during EXPLODING frame 10 -> all outputs 0 asynchronously. After release, a new overlap is accepted immediately with scoreValue=50.
